// File: rtl/traffic_ctrl_ped.sv
// Two-road traffic light controller with pedestrian WALK insertion.
// Optional night flashing mode is compiled in with TRAFFIC_NIGHT_FLASH_EN.
module traffic_ctrl_ped #(
    parameter int unsigned GREEN_T    = 15,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 3,
    parameter int unsigned WALK_T     = 8,
    parameter int unsigned MIN_GREEN  = 5,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] LED_NS,
    output logic [2:0] LED_WE,
    output logic       walk,
    output logic       ped_ack
);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam int unsigned ST_W = 8;
`else
    localparam int unsigned ST_W = 7;
`endif

    typedef enum logic [ST_W-1:0] {
        NSG  = ST_W'(1),
        NSY  = ST_W'(2),
        AR1  = ST_W'(4),
        WEG  = ST_W'(8),
        WEY  = ST_W'(16),
        AR2  = ST_W'(32),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        WALK = ST_W'(64),
        FLASH = ST_W'(128)
`else
        WALK = ST_W'(64)
`endif
    } state_e;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] MING_LAST   = CNT_W'(MIN_GREEN - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // next_grn: 1 selects WE green after WALK, 0 selects NS green
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             next_grn_q, next_grn_d;
    logic             pend_eff;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
    logic flash_q, flash_d;
`else
    logic unused_night;
    assign unused_night = night;
`endif

    assign pend_eff = ped_pend_q | ped_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NSG;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            next_grn_q <= 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            next_grn_q <= next_grn_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_q    <= flash_d;
`endif
        end
    end

    // Phase sequencing, pedestrian bookkeeping and counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        ped_pend_d = pend_eff;
        next_grn_d = next_grn_q;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        flash_d    = flash_q;
`endif
        case (state_q)
            NSG: begin
                if (cnt_q == GREEN_LAST || (pend_eff && cnt_q >= MING_LAST)) begin
                    state_d = NSY;
                    cnt_d   = '0;
                end
            end
            NSY: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = AR1;
                    cnt_d   = '0;
                end
            end
            AR1: begin
                if (cnt_q == ALLRED_LAST) begin
                    cnt_d      = '0;
                    next_grn_d = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (night) begin
                        state_d    = FLASH;
                        ped_pend_d = 1'b0;
                        flash_d    = 1'b0;
                    end else
`endif
                    if (pend_eff) begin
                        state_d    = WALK;
                        ped_pend_d = 1'b0;
                    end else begin
                        state_d = WEG;
                    end
                end
            end
            WEG: begin
                if (cnt_q == GREEN_LAST || (pend_eff && cnt_q >= MING_LAST)) begin
                    state_d = WEY;
                    cnt_d   = '0;
                end
            end
            WEY: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = AR2;
                    cnt_d   = '0;
                end
            end
            AR2: begin
                if (cnt_q == ALLRED_LAST) begin
                    cnt_d      = '0;
                    next_grn_d = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (night) begin
                        state_d    = FLASH;
                        ped_pend_d = 1'b0;
                        flash_d    = 1'b0;
                    end else
`endif
                    if (pend_eff) begin
                        state_d    = WALK;
                        ped_pend_d = 1'b0;
                    end else begin
                        state_d = NSG;
                    end
                end
            end
            WALK: begin
                // a press on the acknowledged cycle is treated as already served
                if (cnt_q == '0) begin
                    ped_pend_d = ped_pend_q;
                end
                if (cnt_q == WALK_LAST) begin
                    state_d = next_grn_q ? WEG : NSG;
                    cnt_d   = '0;
                end
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
                ped_pend_d = 1'b0;
                if (cnt_q == FLASH_LAST) begin
                    cnt_d = '0;
                    if (night) begin
                        flash_d = ~flash_q;
                    end else begin
                        state_d = AR1;
                        flash_d = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = NSG;
                cnt_d   = '0;
            end
        endcase
    end

    // Lamp decode; any unknown state shows all-red
    always_comb begin
        LED_NS  = LAMP_RED;
        LED_WE  = LAMP_RED;
        walk    = 1'b0;
        ped_ack = 1'b0;
        case (state_q)
            NSG:  LED_NS = LAMP_GRN;
            NSY:  LED_NS = LAMP_YEL;
            WEG:  LED_WE = LAMP_GRN;
            WEY:  LED_WE = LAMP_YEL;
            WALK: begin
                walk    = 1'b1;
                ped_ack = (cnt_q == '0);
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
                LED_NS = flash_q ? 3'b000 : LAMP_YEL;
                LED_WE = flash_q ? 3'b000 : LAMP_RED;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_ped.sv
// Directed bench for traffic_ctrl_ped at default parameters (night flashing disabled).
module tb_traffic_ctrl_ped;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] LED_NS;
    logic [2:0] LED_WE;
    logic       walk;
    logic       ped_ack;

    int checks = 0;
    int failures = 0;

    // {LED_NS, LED_WE, walk, ped_ack}
    localparam logic [7:0] V_NSG   = 8'b001_100_0_0;
    localparam logic [7:0] V_NSY   = 8'b010_100_0_0;
    localparam logic [7:0] V_AR    = 8'b100_100_0_0;
    localparam logic [7:0] V_WEG   = 8'b100_001_0_0;
    localparam logic [7:0] V_WEY   = 8'b100_010_0_0;
    localparam logic [7:0] V_WALK1 = 8'b100_100_1_1;
    localparam logic [7:0] V_WALK  = 8'b100_100_1_0;

    traffic_ctrl_ped dut (
        .clk    (clk),
        .rst    (rst),
        .ped_req(ped_req),
        .night  (night),
        .LED_NS (LED_NS),
        .LED_WE (LED_WE),
        .walk   (walk),
        .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        ped_req = 1'b0;
        night   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        @(negedge clk);
        obs = {LED_NS, LED_WE, walk, ped_ack};
        checks++;
        if (obs !== V_NSG) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs, V_NSG);
        end
        apply_reset();
        obs = {LED_NS, LED_WE, walk, ped_ack};
        checks++;
        if (obs !== V_NSG) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs, V_NSG);
        end
    endtask

    task automatic test_normal_cycle();
        logic [7:0] exp_q[$];
        logic [7:0] obs;
        repeat (15) exp_q.push_back(V_NSG);
        repeat (3)  exp_q.push_back(V_NSY);
        repeat (3)  exp_q.push_back(V_AR);
        repeat (15) exp_q.push_back(V_WEG);
        repeat (3)  exp_q.push_back(V_WEY);
        repeat (3)  exp_q.push_back(V_AR);
        repeat (2)  exp_q.push_back(V_NSG);
        apply_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = {LED_NS, LED_WE, walk, ped_ack};
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL normal_cycle cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            step();
        end
    endtask

    task automatic test_ped_ns();
        logic [7:0] exp_q[$];
        logic [7:0] obs;
        repeat (5) exp_q.push_back(V_NSG);
        repeat (3) exp_q.push_back(V_NSY);
        repeat (3) exp_q.push_back(V_AR);
        exp_q.push_back(V_WALK1);
        repeat (7) exp_q.push_back(V_WALK);
        repeat (3) exp_q.push_back(V_WEG);
        apply_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            ped_req = (i == 2);
            obs = {LED_NS, LED_WE, walk, ped_ack};
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL ped_ns cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            step();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_ped_we();
        logic [7:0] exp_q[$];
        logic [7:0] obs;
        repeat (15) exp_q.push_back(V_NSG);
        repeat (3)  exp_q.push_back(V_NSY);
        repeat (3)  exp_q.push_back(V_AR);
        repeat (11) exp_q.push_back(V_WEG);
        repeat (3)  exp_q.push_back(V_WEY);
        repeat (3)  exp_q.push_back(V_AR);
        exp_q.push_back(V_WALK1);
        repeat (7)  exp_q.push_back(V_WALK);
        repeat (3)  exp_q.push_back(V_NSG);
        apply_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            ped_req = (i == 31);
            obs = {LED_NS, LED_WE, walk, ped_ack};
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL ped_we cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            step();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] obs;
        repeat (5) exp_q.push_back(V_NSG);
        repeat (3) exp_q.push_back(V_NSY);
        repeat (3) exp_q.push_back(V_AR);
        exp_q.push_back(V_WALK1);
        repeat (7) exp_q.push_back(V_WALK);
        repeat (5) exp_q.push_back(V_WEG);
        repeat (3) exp_q.push_back(V_WEY);
        repeat (3) exp_q.push_back(V_AR);
        exp_q.push_back(V_WALK1);
        repeat (7) exp_q.push_back(V_WALK);
        repeat (3) exp_q.push_back(V_NSG);
        apply_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            ped_req = (i < 19);
            obs = {LED_NS, LED_WE, walk, ped_ack};
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            step();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        logic [7:0] exp_q[$];
        logic [7:0] obs;
        repeat (15) exp_q.push_back(V_NSG);
        repeat (3)  exp_q.push_back(V_NSY);
        repeat (3)  exp_q.push_back(V_AR);
        repeat (2)  exp_q.push_back(V_WEG);
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            ped_req = (i == 2) || (i == 12);
            step();
        end
        ped_req = 1'b0;
        obs = {LED_NS, LED_WE, walk, ped_ack};
        checks++;
        if (obs !== V_WALK) begin
            failures++;
            $display("FAIL mid_walk_pre got=%b exp=%b", obs, V_WALK);
        end
        #2 rst = 1'b1;
        #1 obs = {LED_NS, LED_WE, walk, ped_ack};
        checks++;
        if (obs !== V_NSG) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs, V_NSG);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = {LED_NS, LED_WE, walk, ped_ack};
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, obs, exp_q[i]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_ns();
        test_ped_we();
        test_back_to_back();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
